// File: rtl/nf_dm_req_ctrl_pkg.sv
// Shared nanoFOX data-memory definitions: request FSM states, access sizes and lane masks.
package nf_dm_req_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } dm_state_e;

    // Size code 3 is not listed and falls through to word handling.
    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    localparam logic [3:0] BeByte = 4'b0001;
    localparam logic [3:0] BeHalf = 4'b0011;
    localparam logic [3:0] BeWord = 4'b1111;

endpackage

// File: rtl/nf_dm_align.sv
// Byte-lane logic for data-memory accesses: store enables/replication and load lane
// extraction with sign or zero extension.
module nf_dm_align
    import nf_dm_req_ctrl_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wd,
    input  logic [31:0] rd_bus,
    output logic [3:0]  be,
    output logic [31:0] wd_rep,
    output logic [31:0] rd_ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfword lanes use only addr[1]; addr[0] is ignored for misaligned accesses.
    assign byte_v = rd_bus[{addr_lo, 3'b000} +: 8];
    assign half_v = rd_bus[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be     = BeWord;
        wd_rep = wd;
        rd_ext = rd_bus;
        case (size)
            SizeByte: begin
                be     = BeByte << addr_lo;
                wd_rep = {4{wd[7:0]}};
                rd_ext = {{24{~uns & byte_v[7]}}, byte_v};
            end
            SizeHalf: begin
                be     = BeHalf << {addr_lo[1], 1'b0};
                wd_rep = {2{wd[15:0]}};
                rd_ext = {{16{~uns & half_v[15]}}, half_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/nf_dm_req_ctrl.sv
// nanoFOX data-memory request controller: latches a MEM-stage access and runs one bus
// handshake (IDLE -> REQ -> DONE). Define NF_DM_TIMEOUT_EN for the ack timeout / dm_err.
module nf_dm_req_ctrl
    import nf_dm_req_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] addr_imem,
    input  logic [31:0] wd_imem,
    input  logic        we_dm_imem,
    input  logic        rf_src_imem,
    input  logic [1:0]  size_imem,
    input  logic        uns_imem,
    output logic        req_ack_dm,
    output logic [31:0] rd_dm,
    output logic [31:0] addr_dm,
    output logic [31:0] wd_dm,
    output logic        we_dm,
    output logic [3:0]  be_dm,
    output logic        req_dm,
    input  logic        ack_dm,
    input  logic [31:0] rd_bus,
    output logic        dm_err
);

    dm_state_e   state_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [31:0] rd_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        store_q;
    logic [3:0]  be_lane;
    logic [31:0] wd_lane;
    logic [31:0] rd_lane;

`ifdef NF_DM_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CntW-1:0] cnt_q;
    logic            err_q;
    logic            timeout;

    assign timeout = (cnt_q == CntW'(TIMEOUT_CYC - 1));
    assign dm_err  = err_q;
`else
    logic unused_timeout_cyc;

    assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
    assign dm_err             = 1'b0;
`endif

    nf_dm_align u_align (
        .addr_lo (addr_q[1:0]),
        .size    (size_q),
        .uns     (uns_q),
        .wd      (wd_q),
        .rd_bus  (rd_bus),
        .be      (be_lane),
        .wd_rep  (wd_lane),
        .rd_ext  (rd_lane)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            store_q <= 1'b0;
`ifdef NF_DM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (we_dm_imem | rf_src_imem) begin
                        addr_q  <= addr_imem;
                        wd_q    <= wd_imem;
                        size_q  <= size_imem;
                        uns_q   <= uns_imem;
                        store_q <= we_dm_imem;
                        state_q <= StReq;
`ifdef NF_DM_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                StReq: begin
                    if (ack_dm) begin
                        if (!store_q) rd_q <= rd_lane;
                        state_q <= StDone;
                    end
`ifdef NF_DM_TIMEOUT_EN
                    else if (timeout) begin
                        if (!store_q) rd_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Bus-side outputs come straight from the latched request, so they stay stable in REQ.
    assign req_dm     = (state_q == StReq);
    assign req_ack_dm = (state_q == StDone);
    assign we_dm      = req_dm & store_q;
    assign be_dm      = req_dm ? be_lane : 4'b0000;
    assign addr_dm    = {addr_q[31:2], 2'b00};
    assign wd_dm      = wd_lane;
    assign rd_dm      = rd_q;

endmodule

// File: tb/tb_nf_dm_req_ctrl.sv
// Self-checking bench for nf_dm_req_ctrl: directed vector table, randomized accesses
// against a lane-arithmetic model, and hand sequences for handshake/reset corner cases.
module tb_nf_dm_req_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] addr_imem, wd_imem, rd_bus;
    logic        we_dm_imem, rf_src_imem, uns_imem, ack_dm;
    logic [1:0]  size_imem;
    logic        req_ack_dm, we_dm, req_dm, dm_err;
    logic [31:0] rd_dm, addr_dm, wd_dm;
    logic [3:0]  be_dm;

    always #5 clk = ~clk;

`ifdef NF_DM_TIMEOUT_EN
    localparam int LongAck = 3;
`else
    localparam int LongAck = 5;
`endif

    nf_dm_req_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .addr_imem   (addr_imem),
        .wd_imem     (wd_imem),
        .we_dm_imem  (we_dm_imem),
        .rf_src_imem (rf_src_imem),
        .size_imem   (size_imem),
        .uns_imem    (uns_imem),
        .req_ack_dm  (req_ack_dm),
        .rd_dm       (rd_dm),
        .addr_dm     (addr_dm),
        .wd_dm       (wd_dm),
        .we_dm       (we_dm),
        .be_dm       (be_dm),
        .req_dm      (req_dm),
        .ack_dm      (ack_dm),
        .rd_bus      (rd_bus),
        .dm_err      (dm_err)
    );

    typedef struct {
        logic        st;
        logic        ld;
        logic [31:0] a;
        logic [31:0] w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] bus;
        int          nreq;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;

    vec_t        vecs [11];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: lane positions from plain arithmetic on the address.
    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'(1 << (a % 4));
        if (sz == 2'd1) return 4'(3 << (a & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return w[7:0] * 32'h0101_0101;
        if (sz == 2'd1) return w[15:0] * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] sz, input logic [31:0] a,
                                         input logic u, input logic [31:0] bus);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (bus >> (8 * (a % 4))) & 32'hFF;
            if (!u && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            v = (bus >> (8 * (a & 2))) & 32'hFFFF;
            if (!u && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = bus;
        end
        return v;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, " req_dm"}, 32'(req_dm), 32'd0);
        chk({tag, " we_dm"}, 32'(we_dm), 32'd0);
        chk({tag, " be_dm"}, 32'(be_dm), 32'd0);
        chk({tag, " req_ack_dm"}, 32'(req_ack_dm), 32'd0);
    endtask

    // One complete access; entered and left in IDLE, ack given in the nreq-th REQ cycle.
    task automatic run_txn(input string tag, input logic st, input logic ld,
                           input logic [31:0] a, input logic [31:0] w, input logic [1:0] sz,
                           input logic u, input logic [31:0] bus, input int nreq,
                           input logic [3:0] ebe, input logic [31:0] ewd,
                           input logic [31:0] erd);
        logic [31:0] eaddr;
        eaddr = {a[31:2], 2'b00};
        chk({tag, " idle req_dm"}, 32'(req_dm), 32'd0);
        we_dm_imem  = st;
        rf_src_imem = ld;
        addr_imem   = a;
        wd_imem     = w;
        size_imem   = sz;
        uns_imem    = u;
        tick();
        we_dm_imem  = 1'b0;
        rf_src_imem = 1'b0;
        addr_imem   = $urandom;
        wd_imem     = $urandom;
        size_imem   = 2'($urandom);
        uns_imem    = 1'($urandom);
        for (int i = 0; i < nreq; i++) begin
            chk({tag, " req_dm"}, 32'(req_dm), 32'd1);
            chk({tag, " req_ack_dm low"}, 32'(req_ack_dm), 32'd0);
            chk({tag, " we_dm"}, 32'(we_dm), 32'(st));
            chk({tag, " be_dm"}, 32'(be_dm), 32'(ebe));
            chk({tag, " addr_dm"}, addr_dm, eaddr);
            if (st) chk({tag, " wd_dm"}, wd_dm, ewd);
            if (i == nreq - 1) begin
                ack_dm = 1'b1;
                rd_bus = bus;
            end else begin
                rd_bus = $urandom;
            end
            tick();
        end
        ack_dm = 1'b0;
        rd_bus = $urandom;
        if (ld && !st) exp_rd = erd;
        chk({tag, " done req_ack_dm"}, 32'(req_ack_dm), 32'd1);
        chk({tag, " done req_dm"}, 32'(req_dm), 32'd0);
        chk({tag, " done be_dm"}, 32'(be_dm), 32'd0);
        chk({tag, " rd_dm"}, rd_dm, exp_rd);
        tick();
        chk({tag, " post req_ack_dm"}, 32'(req_ack_dm), 32'd0);
        chk({tag, " post rd_dm"}, rd_dm, exp_rd);
    endtask

    initial begin
        logic [31:0] ra, rw, rb;
        logic [1:0]  rsz;
        logic        rst, rld, ru;
        int          cnt;

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0, 1,
                     4'hF, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0103, 32'h0, 2'd0, 1'b0, 32'h8000_0000, 1,
                     4'h8, 32'h0, 32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0103, 32'h0, 2'd0, 1'b1, 32'h8000_0000, 1,
                     4'h8, 32'h0, 32'h0000_0080};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0022, 32'h0000_1234, 2'd1, 1'b0, 32'h0, 1,
                     4'hC, 32'h1234_1234, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0022, 32'h0, 2'd1, 1'b0, 32'h8001_1234, 2,
                     4'hC, 32'h0, 32'hFFFF_8001};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0041, 32'h0000_00AB, 2'd0, 1'b0, 32'h0, 1,
                     4'h2, 32'hABAB_ABAB, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0107, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, 1,
                     4'hF, 32'h0, 32'hCAFE_F00D};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h1122_3344, 2'd3, 1'b0, 32'h0, 1,
                     4'hF, 32'h1122_3344, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0300, 32'h0000_005A, 2'd0, 1'b0, 32'h1234_5678, 1,
                     4'h1, 32'h5A5A_5A5A, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0101, 32'h0, 2'd0, 1'b0, 32'h0000_7F00, 1,
                     4'h2, 32'h0, 32'h0000_007F};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0021, 32'h0, 2'd1, 1'b1, 32'h0000_FFFE, LongAck,
                     4'h3, 32'h0, 32'h0000_FFFE};

        resetn      = 1'b0;
        we_dm_imem  = 1'b0;
        rf_src_imem = 1'b0;
        addr_imem   = '0;
        wd_imem     = '0;
        size_imem   = '0;
        uns_imem    = 1'b0;
        ack_dm      = 1'b0;
        rd_bus      = '0;
        #1;
        chk_quiet("reset");
        chk("reset rd_dm", rd_dm, 32'h0);
        chk("reset addr_dm", addr_dm, 32'h0);
        chk("reset wd_dm", wd_dm, 32'h0);
        chk("reset dm_err", 32'(dm_err), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        chk_quiet("idle");

        foreach (vecs[i]) begin
            run_txn($sformatf("vec%0d", i), vecs[i].st, vecs[i].ld, vecs[i].a, vecs[i].w,
                    vecs[i].sz, vecs[i].u, vecs[i].bus, vecs[i].nreq, vecs[i].be,
                    vecs[i].wd, vecs[i].rd);
        end

        for (int i = 0; i < 40; i++) begin
            rst = 1'($urandom);
            rld = rst ? 1'($urandom) : 1'b1;
            ra  = $urandom;
            rw  = $urandom;
            rb  = $urandom;
            rsz = 2'($urandom);
            ru  = 1'($urandom);
            run_txn($sformatf("rnd%0d", i), rst, rld, ra, rw, rsz, ru, rb,
                    int'($urandom_range(1, 3)), m_be(rsz, ra), m_wd(rsz, rw),
                    m_rd(rsz, ra, ru, rb));
        end

        // Request held through DONE must not be taken until IDLE.
        we_dm_imem = 1'b1;
        addr_imem  = 32'h0000_0500;
        wd_imem    = 32'h0;
        size_imem  = 2'd2;
        tick();
        ack_dm = 1'b1;
        tick();
        ack_dm    = 1'b0;
        addr_imem = 32'h0000_0604;
        chk("hold done req_ack_dm", 32'(req_ack_dm), 32'd1);
        tick();
        chk("hold idle req_dm", 32'(req_dm), 32'd0);
        chk("hold idle req_ack_dm", 32'(req_ack_dm), 32'd0);
        tick();
        we_dm_imem = 1'b0;
        chk("hold second req_dm", 32'(req_dm), 32'd1);
        chk("hold second addr_dm", addr_dm, 32'h0000_0604);
        ack_dm = 1'b1;
        tick();
        ack_dm = 1'b0;
        chk("hold second req_ack_dm", 32'(req_ack_dm), 32'd1);
        tick();

        // Reset in the middle of REQ abandons the transfer.
        rf_src_imem = 1'b1;
        addr_imem   = 32'h0000_0404;
        tick();
        rf_src_imem = 1'b0;
        chk("rst mid req_dm before", 32'(req_dm), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk_quiet("rst mid");
        chk("rst mid addr_dm", addr_dm, 32'h0);
        chk("rst mid rd_dm", rd_dm, 32'h0);
        chk("rst mid dm_err", 32'(dm_err), 32'd0);
        exp_rd = '0;
        ack_dm = 1'b1;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst after req_ack_dm", 32'(req_ack_dm), 32'd0);
            chk("rst after req_dm", 32'(req_dm), 32'd0);
        end
        ack_dm = 1'b0;

`ifdef NF_DM_TIMEOUT_EN
        rf_src_imem = 1'b1;
        addr_imem   = 32'h0000_0700;
        size_imem   = 2'd2;
        rd_bus      = 32'hFFFF_FFFF;
        tick();
        rf_src_imem = 1'b0;
        cnt = 0;
        while (!req_ack_dm && cnt < 20) begin
            if (req_dm) cnt++;
            tick();
        end
        exp_rd = '0;
        chk("timeout req cycles", 32'(cnt), 32'd4);
        chk("timeout req_ack_dm", 32'(req_ack_dm), 32'd1);
        chk("timeout dm_err", 32'(dm_err), 32'd1);
        chk("timeout rd_dm", rd_dm, 32'h0);
        tick();
        run_txn("after timeout", 1'b1, 1'b0, 32'h10, 32'h55, 2'd2, 1'b0, 32'h0, 1, 4'hF,
                32'h55, 32'h0);
        chk("timeout dm_err sticky", 32'(dm_err), 32'd1);
`else
        rf_src_imem = 1'b1;
        addr_imem   = 32'h0000_0700;
        size_imem   = 2'd2;
        tick();
        rf_src_imem = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_dm) cnt++;
            tick();
        end
        chk("no timeout req cycles", 32'(cnt), 32'd20);
        chk("no timeout dm_err", 32'(dm_err), 32'd0);
        ack_dm = 1'b1;
        rd_bus = 32'h0BAD_F00D;
        tick();
        ack_dm = 1'b0;
        exp_rd = 32'h0BAD_F00D;
        chk("late ack req_ack_dm", 32'(req_ack_dm), 32'd1);
        chk("late ack rd_dm", rd_dm, exp_rd);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
